// File: rtl/spi_dac_pkg.sv
// Shared types and defaults for the DAC-side SPI receive stage.
`timescale 1ns/1ps
package spi_dac_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    COMMIT
  } rx_state_e;

  typedef logic [DATA_W_DEF-1:0] dac_word_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser plus one history flop; gives the synced level and its rise/fall strobes.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // NOTE: non-blocking assignments so each stage captures its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_dac_rx.sv
// SPI receive stage for DAC frames: deserialises sclk/cs/mosi into valid/ready words.
// Define SPI_DAC_RX_FRAMECNT_EN to add the 16-bit committed-frame counter output frame_cnt.
`timescale 1ns/1ps
module spi_dac_rx
  import spi_dac_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
`ifdef SPI_DAC_RX_FRAMECNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_level;
  logic w_cs_rise, w_cs_fall, w_cs_level;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // Strobes the shared synchroniser provides but this receiver has no use for.
  logic w_unused_edges;
  assign w_unused_edges = ^{w_sclk_level, w_sclk_fall, w_cs_level, w_mosi_rise, w_mosi_fall};

  rx_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_bad;
  logic              r_frame_err;
  logic              r_overrun;

  logic w_clr, w_shift_en, w_set_bad, w_ferr, w_load, w_ovr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift_en  = 1'b0;
    w_set_bad   = 1'b0;
    w_ferr      = 1'b0;
    w_load      = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_clr       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_fall) begin
          w_clr = 1'b1;
        end else if (w_cs_rise) begin
          w_ferr      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (w_cs_fall) begin
          w_clr       = 1'b1;
          w_state_nxt = SHIFT;
        end else if (w_cs_rise) begin
          w_state_nxt = r_bad ? IDLE : COMMIT;
        end else if (w_sclk_rise && !r_bad) begin
          w_ferr    = 1'b1;
          w_set_bad = 1'b1;
        end
      end
      COMMIT: begin
        w_state_nxt = IDLE;
        if (!r_dout_valid || dout_ready) w_load = 1'b1;
        else                             w_ovr  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_bad        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_clr)           r_cnt <= '0;
      else if (w_shift_en) r_cnt <= r_cnt + CNT_W'(1);

      if (w_shift_en) begin
        if (LSB_FIRST) r_shift <= {w_mosi, r_shift[DATA_W-1:1]};
        else           r_shift <= {r_shift[DATA_W-2:0], w_mosi};
      end

      if (w_clr)          r_bad <= 1'b0;
      else if (w_set_bad) r_bad <= 1'b1;

      // A commit load takes precedence over the consumer draining the old word.
      if (w_load) begin
        r_dout       <= r_shift;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

`ifdef SPI_DAC_RX_FRAMECNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_frame_cnt <= '0;
    else if (w_load) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
